// File: rtl/phase_increment_bank.sv
// Purpose: per-channel phase increment INC = floor(Freq * SCALE / UPDATE_RATE), FRAC_W fraction bits.
// Latency: FREQ_W+35 enabled cycles from a dirty channel being seen in IDLE to its Inc_valid pulse.
// Backpressure: none; Inc_ce low freezes all state and masks Inc_valid.
//
// Ports:
//   Sys_clk    system clock
//   Inc_rst    synchronous active-high reset (wins over Inc_ce)
//   Inc_ce     clock enable
//   Freq_flat  channel n frequency at [n*FREQ_W +: FREQ_W]
//   Inc_flat   channel n increment at [n*INC_W +: INC_W]
//   Inc_valid  one-cycle pulse per channel while its new increment is presented
//   Busy       high whenever the sequencer is not idle
//
// Build option: define PHASE_INC_ROUND_NEAREST_EN to round half-up instead of truncating.
// Cycle count is the same in both builds.
//
// One multiplier and one bit-serial restoring divider are shared across all channels.
// Channels are served round-robin, starting from the channel after the last one written.
// A channel is dirty when its Freq differs from its shadow copy. The shadow is updated
// when the channel is picked, so a change arriving mid-computation is picked up on a later pass.
//
// Assumes FRAC_W <= 16, so the aligned dividend fits in FREQ_W+32 bits. Also assumes INC_W <= FREQ_W+32.
module phase_increment_bank #(
   parameter int          CHANNELS    = 4,
   parameter int          FREQ_W      = 32,
   parameter int          INC_W       = 32,
   parameter int          FRAC_W      = 16,
   parameter logic [31:0] SCALE       = 32'h0006487E,
   parameter int unsigned UPDATE_RATE = 1000000
) (
   input  logic                       Sys_clk,
   input  logic                       Inc_rst,
   input  logic                       Inc_ce,
   input  logic [CHANNELS*FREQ_W-1:0] Freq_flat,
   output logic [CHANNELS*INC_W-1:0]  Inc_flat,
   output logic [CHANNELS-1:0]        Inc_valid,
   output logic                       Busy
);

   localparam int D  = FREQ_W + 32;               // product / dividend / quotient width
   localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CW = $clog2(D);                 // holds D-1
   localparam logic [PW:0]  CH_L = (PW+1)'(CHANNELS);
   localparam logic [31:0]  RATE = 32'(UPDATE_RATE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_MUL,
      S_DIV,
      S_WRITE
   } state_t;

   state_t state_q, state_d;

   logic [FREQ_W-1:0] freq_ch   [CHANNELS];
   logic [FREQ_W-1:0] shadow_q  [CHANNELS];
   logic [INC_W-1:0]  inc_q     [CHANNELS];
   logic [CHANNELS-1:0] dirty;
   logic              any_dirty;

   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     sel_q;
   logic [FREQ_W-1:0] work_q;
   logic [D-1:0]      acc_q;     // dividend shifts out the top, quotient bits shift in the bottom
   logic [31:0]       rem_q;
   logic [CW-1:0]     cnt_q;

   // ------------------------------------------------------------------
   // Channel unpacking and dirty detection
   // ------------------------------------------------------------------
   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_ch
         assign freq_ch[g] = Freq_flat[g*FREQ_W +: FREQ_W];
         assign dirty[g]   = (freq_ch[g] != shadow_q[g]);
         assign Inc_flat[g*INC_W +: INC_W] = inc_q[g];
      end
   endgenerate

   assign any_dirty = |dirty;

   // ------------------------------------------------------------------
   // Round-robin pick: first dirty channel at or after ptr_q, wrapping
   // ------------------------------------------------------------------
   logic          pick_found;
   logic [PW-1:0] pick_idx;
   logic [PW:0]   scan_idx;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         scan_idx = {1'b0, ptr_q} + (PW+1)'(i);
         if (scan_idx >= CH_L) begin
            scan_idx = scan_idx - CH_L;
         end
         if (!pick_found && dirty[scan_idx[PW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx[PW-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath: multiply, align SCALE's 16 fraction bits to FRAC_W, divide
   // ------------------------------------------------------------------
   logic [D-1:0]        product;
   logic [D+FRAC_W-1:0] shifted;
   logic [D-1:0]        dividend_load;

   assign product = D'(work_q) * D'(SCALE);
   assign shifted = (D+FRAC_W)'(product) << FRAC_W;

`ifdef PHASE_INC_ROUND_NEAREST_EN
   localparam logic [D-1:0] HALF_RATE = D'(UPDATE_RATE / 2);
   assign dividend_load = D'(shifted >> 16) + HALF_RATE;
`else
   assign dividend_load = D'(shifted >> 16);
`endif

   // One restoring step: bring down the next dividend bit, subtract if it fits
   logic [32:0]  trial;
   logic         q_bit;
   logic [31:0]  rem_next;
   logic [D-1:0] acc_next;

   assign trial    = {rem_q, acc_q[D-1]};
   assign q_bit    = (trial >= {1'b0, RATE});
   assign rem_next = q_bit ? 32'(trial - {1'b0, RATE}) : trial[31:0];
   assign acc_next = {acc_q[D-2:0], q_bit};

   // acc_next holds the complete quotient on the final DIV step
   logic             quo_ovf;
   logic [INC_W-1:0] sat_result;

   assign quo_ovf    = |(acc_next >> INC_W);
   assign sat_result = quo_ovf ? {INC_W{1'b1}} : acc_next[INC_W-1:0];

   // Pointer advance after a write, wrapping modulo CHANNELS
   logic [PW:0]   sel_inc;
   logic [PW-1:0] ptr_next;

   assign sel_inc  = {1'b0, sel_q} + (PW+1)'(1);
   assign ptr_next = (sel_inc >= CH_L) ? '0 : sel_inc[PW-1:0];

   // ------------------------------------------------------------------
   // Sequencer: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      Inc_valid = '0;
      Busy      = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:  if (any_dirty) state_d = S_SCAN;
         S_SCAN:  state_d = pick_found ? S_MUL : S_IDLE;
         S_MUL:   state_d = S_DIV;
         S_DIV:   if (cnt_q == '0) state_d = S_WRITE;
         S_WRITE: begin
            state_d = S_SCAN;
            if (Inc_ce && !Inc_rst) begin
               Inc_valid[sel_q] = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge Sys_clk) begin
      if (Inc_rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         work_q  <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            shadow_q[n] <= '0;
            inc_q[n]    <= '0;
         end
      end else if (Inc_ce) begin
         state_q <= state_d;
         case (state_q)
            S_SCAN: begin
               if (pick_found) begin
                  sel_q              <= pick_idx;
                  work_q             <= freq_ch[pick_idx];
                  shadow_q[pick_idx] <= freq_ch[pick_idx];
               end
            end
            S_MUL: begin
               // The registered product lives in acc_q as the divider's dividend
               acc_q <= dividend_load;
               rem_q <= '0;
               cnt_q <= CW'(D - 1);
            end
            S_DIV: begin
               acc_q <= acc_next;
               rem_q <= rem_next;
               cnt_q <= cnt_q - CW'(1);
               // Commit on the final step so the new value is on Inc_flat during the pulse
               if (cnt_q == '0) begin
                  inc_q[sel_q] <= sat_result;
               end
            end
            S_WRITE: ptr_q <= ptr_next;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_phase_increment_bank.sv
// Purpose: directed self-checking bench for phase_increment_bank (plus a 24-bit saturating instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_phase_increment_bank;

   localparam int CH = 4;
   localparam int FW = 32;
   localparam int IW = 32;
   localparam int SW = 24;

   localparam logic [63:0] EXP_440  = 64'd181;
   localparam logic [63:0] EXP_880  = 64'd362;
`ifdef PHASE_INC_ROUND_NEAREST_EN
   localparam logic [63:0] EXP_1000 = 64'd412;
`else
   localparam logic [63:0] EXP_1000 = 64'd411;
`endif

   logic              Sys_clk = 1'b0;
   logic              inc_rst;
   logic              inc_ce;
   logic [CH*FW-1:0]  freq_flat;
   logic [CH*IW-1:0]  inc_flat;
   logic [CH-1:0]     inc_valid;
   logic              busy;

   logic [CH*FW-1:0]  sat_freq;
   logic [CH*SW-1:0]  sat_inc;
   logic [CH-1:0]     sat_valid;
   logic              sat_busy;

   int n_chk = 0;
   int n_err = 0;
   int pc [CH] = '{0, 0, 0, 0};
   int lat, lat2, base;

   always #5 Sys_clk = ~Sys_clk;

   phase_increment_bank dut (
      .Sys_clk   (Sys_clk),
      .Inc_rst   (inc_rst),
      .Inc_ce    (inc_ce),
      .Freq_flat (freq_flat),
      .Inc_flat  (inc_flat),
      .Inc_valid (inc_valid),
      .Busy      (busy)
   );

   phase_increment_bank #(.INC_W(SW)) dut_sat (
      .Sys_clk   (Sys_clk),
      .Inc_rst   (inc_rst),
      .Inc_ce    (inc_ce),
      .Freq_flat (sat_freq),
      .Inc_flat  (sat_inc),
      .Inc_valid (sat_valid),
      .Busy      (sat_busy)
   );

   // Pulse counter, sampled mid-cycle
   always @(negedge Sys_clk) begin
      for (int i = 0; i < CH; i++) begin
         if (inc_valid[i]) pc[i] <= pc[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge Sys_clk);
      #1;
   endtask

   task automatic set_freq(input int ch, input logic [31:0] val);
      freq_flat[ch*FW +: FW] = val;
   endtask

   function automatic logic [63:0] inc_of(input int ch);
      return 64'(inc_flat[ch*IW +: IW]);
   endfunction

   // Count enabled edges until inc_valid[ch] is seen; -1 on timeout
   task automatic wait_pulse(input int ch, input int budget, output int cyc);
      cyc = 0;
      while (cyc < budget) begin
         tick();
         cyc++;
         if (inc_valid[ch]) return;
      end
      cyc = -1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      inc_rst   = 1'b1;
      inc_ce    = 1'b1;
      freq_flat = '0;
      sat_freq  = '0;
      repeat (3) tick();
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_inc",   64'(inc_flat == '0), 64'd1);
      chk("rst_valid", 64'(inc_valid), 64'd0);
      inc_rst = 1'b0;
      tick();
      chk("idle_busy", 64'(busy), 64'd0);

      // Single channel, plus saturation on the 24-bit instance
      set_freq(0, 32'd440);
      sat_freq[0 +: FW] = 32'hFFFF_FFFF;
      wait_pulse(0, 200, lat);
      chk("ch0_lat",    64'(lat), 64'd67);
      chk("ch0_inc",    inc_of(0), EXP_440);
      chk("sat_valid",  64'(sat_valid), 64'd1);
      chk("sat_inc",    64'(sat_inc[0 +: SW]), 64'hFF_FFFF);
      tick();
      tick();
      chk("ch0_done_busy", 64'(busy), 64'd0);
      chk("ch0_pulses",    64'(pc[0]), 64'd1);
      chk("other_pulses",  64'(pc[1] + pc[2] + pc[3]), 64'd0);
      chk("other_inc",     64'(inc_flat[CH*IW-1:IW] == '0), 64'd1);

      // Channel 2
      set_freq(2, 32'd1000);
      wait_pulse(2, 200, lat);
      chk("ch2_lat", 64'(lat), 64'd67);
      chk("ch2_inc", inc_of(2), EXP_1000);
      chk("ch2_ch0_kept", inc_of(0), EXP_440);

      // Round-robin from pointer 0 with two simultaneous changes
      inc_rst   = 1'b1;
      freq_flat = '0;
      tick();
      inc_rst = 1'b0;
      tick();
      set_freq(1, 32'd440);
      set_freq(3, 32'd1000);
      wait_pulse(1, 200, lat);
      chk("rr_ch1_lat", 64'(lat), 64'd67);
      chk("rr_ch1_inc", inc_of(1), EXP_440);
      chk("rr_ch3_pending", inc_of(3), 64'd0);
      wait_pulse(3, 200, lat2);
      chk("rr_ch3_total", 64'(lat + lat2), 64'd134);
      chk("rr_ch3_inc", inc_of(3), EXP_1000);

      // Frequency change during computation
      set_freq(0, 32'd440);
      repeat (30) tick();
      set_freq(0, 32'd880);
      wait_pulse(0, 200, lat);
      chk("chg_first_lat", 64'(lat), 64'd37);
      chk("chg_first_inc", inc_of(0), EXP_440);
      wait_pulse(0, 200, lat);
      chk("chg_second_lat", 64'(lat), 64'd67);
      chk("chg_second_inc", inc_of(0), EXP_880);

      // Value returning to its shadow before being served is not recomputed
      base = pc[2];
      set_freq(0, 32'd440);
      repeat (5) tick();
      set_freq(2, 32'd7);
      repeat (5) tick();
      set_freq(2, 32'd0);
      wait_pulse(0, 200, lat);
      chk("ret_ch0_lat", 64'(lat), 64'd57);
      tick();
      tick();
      chk("ret_busy",   64'(busy), 64'd0);
      chk("ret_pulses", 64'(pc[2] - base), 64'd0);
      chk("ret_inc2",   inc_of(2), 64'd0);

      // Clock enable held low 10 cycles mid-computation
      set_freq(0, 32'd880);
      repeat (20) tick();
      inc_ce = 1'b0;
      repeat (10) tick();
      chk("ce_frozen_busy", 64'(busy), 64'd1);
      inc_ce = 1'b1;
      wait_pulse(0, 200, lat);
      chk("ce_total_lat", 64'(20 + 10 + lat), 64'd77);
      chk("ce_inc", inc_of(0), EXP_880);
      tick();
      tick();

      // Clock enable low during the write cycle masks and defers the pulse
      set_freq(0, 32'd440);
      wait_pulse(0, 200, lat);
      chk("cew_lat", 64'(lat), 64'd67);
      base = pc[0];
      inc_ce = 1'b0;
      tick();
      chk("cew_masked", 64'(inc_valid), 64'd0);
      chk("cew_busy",   64'(busy), 64'd1);
      inc_ce = 1'b1;
      #1;
      chk("cew_resumed", 64'(inc_valid), 64'd1);
      tick();
      chk("cew_one_pulse", 64'(pc[0] - base), 64'd1);
      tick();

      // Reset mid-division aborts without writing
      set_freq(0, 32'd880);
      repeat (20) tick();
      base = pc[0];
      inc_rst = 1'b1;
      tick();
      chk("rstdiv_busy",  64'(busy), 64'd0);
      chk("rstdiv_inc",   64'(inc_flat == '0), 64'd1);
      chk("rstdiv_valid", 64'(inc_valid), 64'd0);
      freq_flat = '0;
      tick();
      inc_rst = 1'b0;
      repeat (80) tick();
      chk("rstdiv_no_pulse", 64'(pc[0] - base), 64'd0);
      chk("rstdiv_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/phase_increment_bank.md
Name: phase_increment_bank

Overview:
- Multi-channel successor to the single-channel sinusoid phase-increment calculator.
- For each of CHANNELS oscillators, computes INC = floor(Freq x SCALE / UPDATE_RATE) in unsigned fixed point with FRAC_W fractional bits.
- A single shared multiplier and a bit-serial restoring divider are time-shared round-robin. No vendor cores are used.
- Sits between the frequency/control register file and the oscillator phase accumulators.

Parameters:
- CHANNELS, 4: number of oscillator channels.
- FREQ_W, 32: width of each integer frequency input (Hz).
- INC_W, 32: width of each increment output.
- FRAC_W, 16: fractional bits of the increment output.
- SCALE, 'h0006487E: 32-bit multiplier constant in 16Q.16N format. Default is 2*pi.
- UPDATE_RATE, 1000000: oscillator update rate (Hz). Used as the divisor; must be nonzero.

Ports:
- Sys_clk, in, 1: system clock.
- Inc_rst, in, 1: synchronous active-high reset.
- Inc_ce, in, 1: active-high clock enable.
- Freq_flat, in, CHANNELS*FREQ_W: channel n frequency occupies bits [n*FREQ_W +: FREQ_W].
- Inc_flat, out, CHANNELS*INC_W: channel n increment occupies bits [n*INC_W +: INC_W].
- Inc_valid, out, CHANNELS: one-cycle pulse per channel when its increment register is updated.
- Busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset and clock enable:
  - Inc_rst takes priority over Inc_ce.
  - On reset: all Inc_flat = 0, all shadow frequencies = 0, Inc_valid = 0, Busy = 0, FSM = IDLE, round-robin pointer = 0.
  - Reset mid-computation aborts the computation; nothing is written.
  - Inc_ce low freezes all state. Inc_valid is forced low while Inc_ce is low.
- Shadow registers: each channel has a FREQ_W-bit shadow. A channel is "dirty" when Freq_n != shadow_n.
- FSM, one transition per enabled clock:
  - IDLE: if any channel is dirty, go to SCAN.
  - SCAN: select the first dirty channel at or after the pointer, wrapping modulo CHANNELS. Latch its Freq into both a work register and its shadow. Go to MUL. If no channel is dirty, go to IDLE.
  - MUL: P = work x SCALE, D = FREQ_W+32 bits, registered. Load the divider. Go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first. Runs exactly D cycles, then go to WRITE.
  - WRITE: apply scaling and saturation, write Inc_n, pulse Inc_valid[n] for this cycle only, set pointer = n+1 (wrapping). Go to SCAN.
- Arithmetic:
  - Dividend = P << FRAC_W >> 16 (align 16Q.16N SCALE to FRAC_W).
  - Quotient is truncated (floor).
  - If the quotient is >= 2^INC_W, the output saturates to all ones.
- Latency: exactly D+3 enabled cycles from the first IDLE cycle that sees a dirty channel to its Inc_valid pulse. This is 67 with default parameters.
- Freq changes during a computation:
  - The result written is for the latched value.
  - The channel becomes dirty again and is recomputed on a later pass. A stale value is never left indefinitely.
- Simultaneous dirty channels are served one at a time in round-robin order from the pointer. This gives no starvation.
- A Freq that returns to its shadow value before being served is not recomputed.

Optional Feature:
- Macro: PHASE_INC_ROUND_NEAREST_EN.
- Defined: UPDATE_RATE/2 (floor) is added to the dividend before division, giving round-half-up. The saturation rule still applies.
- Undefined: truncation. Latency is identical in both builds.

Test Plan:
- Reset, then Freq ch0 = 440, others 0, Inc_ce = 1:
  - Inc_valid[0] pulses 67 cycles after the change.
  - Inc ch0 = 181 (0x000000B5); other channels remain 0 with no pulses.
- Freq ch2 = 1000:
  - Inc ch2 = 411 (0x19B) with truncation.
  - Inc ch2 = 412 (0x19C) with PHASE_INC_ROUND_NEAREST_EN.
- Pointer at 0; ch1 = 440 and ch3 = 1000 change in the same cycle:
  - ch1 valid at cycle 67 = 181.
  - ch3 valid at cycle 134 = 411 (truncation build).
- ch0 changes 440 -> 880 at cycle 30 of its computation:
  - First pulse writes 181.
  - A second pulse 67 cycles later (SCAN follows WRITE) writes 362.
- With INC_W = 24, Freq ch0 = 0xFFFFFFFF: Inc ch0 = 0xFFFFFF (saturated).
- Inc_rst asserted mid-DIV:
  - Next cycle: Busy = 0, outputs 0, no Inc_valid pulse.
  - Holding Inc_ce low for 10 cycles mid-computation extends latency by exactly 10 cycles.
